xrs_bypass: RTL and testbench

//  Parametrised integer register file for the KCP53K-family execute stage: 1 write, 2 read ports.

---
 rtl/xrs_pkg.sv | 15 +
 rtl/xrs_ext.sv | 41 ++++
 rtl/xrs_bypass.sv | 109 ++++++++++
 tb/tb_xrs_bypass.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xrs_pkg.sv
// Shared encodings for the xrs_bypass register file: write-size codes and
// the scrub/ready state enum.
package xrs_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  typedef enum logic {
    SCRUB = 1'b0,
    READY = 1'b1
  } xrs_state_e;

endpackage

// File: rtl/xrs_ext.sv
// Combinational write-data extension: selects an 8/16/32/XLEN-bit field and
// fills the upper bits with the field MSB (sign) or zero.
module xrs_ext
  import xrs_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdat_i,
  input  logic [1:0]      wsz_i,
  input  logic            wsx_i,
  output logic [XLEN-1:0] ext_o
);

  int   w_len;
  logic w_fill;

  always_comb begin
    w_len  = XLEN;
    w_fill = 1'b0;
    case (wsz_i)
      SZ_B: begin
        w_len  = 8;
        w_fill = wsx_i & rdat_i[7];
      end
      SZ_H: begin
        w_len  = 16;
        w_fill = wsx_i & rdat_i[15];
      end
      SZ_W: begin
        w_len  = 32;
        w_fill = wsx_i & rdat_i[31];
      end
      default: ;
    endcase
    // Bits at or above the field width take the fill value; at XLEN=32 SZ_W copies everything.
    for (int i = 0; i < XLEN; i++) begin
      ext_o[i] = (i < w_len) ? rdat_i[i] : w_fill;
    end
  end

endmodule

// File: rtl/xrs_bypass.sv
// 1W/2R integer register file with write-data extension, same-cycle
// write-to-read bypass and a post-reset zeroing scrub (busy_o while active).
module xrs_bypass
  import xrs_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            we_i,
  input  logic [AW-1:0]   rd_i,
  input  logic [1:0]      wsz_i,
  input  logic            wsx_i,
  input  logic [XLEN-1:0] rdat_i,
  input  logic [AW-1:0]   ra_i,
  input  logic [AW-1:0]   rb_i,
  output logic [XLEN-1:0] rdata_o,
  output logic [XLEN-1:0] rdatb_o,
  output logic            busy_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  xrs_state_e      r_state;
  xrs_state_e      w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [XLEN-1:0] w_ext;
  logic [XLEN-1:0] w_rda;
  logic [XLEN-1:0] w_rdb;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_rdatb;
  logic            w_scrub;

  // Single extension instance shared by the array write and the bypass path.
  xrs_ext #(.XLEN(XLEN)) u_ext (
    .rdat_i (rdat_i),
    .wsz_i  (wsz_i),
    .wsx_i  (wsx_i),
    .ext_o  (w_ext)
  );

  assign w_scrub = (r_state == SCRUB);

  always_comb begin
    w_state_nxt = r_state;
    if (w_scrub && (r_idx == LAST_IDX)) begin
      w_state_nxt = READY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= SCRUB;
      r_idx   <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      if (w_scrub) begin
        r_idx <= r_idx + AW'(1);
      end
    end
  end

  // Array has no reset of its own; the scrub walks entries 1..NREGS-1 after reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (w_scrub) begin
        r_regs[r_idx] <= '0;
      end else if (we_i && (rd_i != '0)) begin
        r_regs[rd_i] <= w_ext;
      end
    end
  end

  always_comb begin
    w_rda = r_regs[ra_i];
    if (ra_i == '0) begin
      w_rda = '0;
    end else if (we_i && (rd_i == ra_i)) begin
      w_rda = w_ext;
    end
  end

  always_comb begin
    w_rdb = r_regs[rb_i];
    if (rb_i == '0) begin
      w_rdb = '0;
    end else if (we_i && (rd_i == rb_i)) begin
      w_rdb = w_ext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || w_scrub) begin
      r_rdata <= '0;
      r_rdatb <= '0;
    end else begin
      r_rdata <= w_rda;
      r_rdatb <= w_rdb;
    end
  end

  assign rdata_o = r_rdata;
  assign rdatb_o = r_rdatb;
  assign busy_o  = w_scrub;

endmodule

// File: tb/tb_xrs_bypass.sv
// Directed bench for xrs_bypass: a 64-bit/32-entry instance and a
// 32-bit/8-entry instance sharing one clock, each with its own reset.
module tb_xrs_bypass;

  logic clk;

  logic        a_reset, a_we, a_wsx;
  logic [4:0]  a_rd, a_ra, a_rb;
  logic [1:0]  a_wsz;
  logic [63:0] a_rdat, a_rdata, a_rdatb;
  logic        a_busy;

  logic        b_reset, b_we, b_wsx;
  logic [2:0]  b_rd, b_ra, b_rb;
  logic [1:0]  b_wsz;
  logic [31:0] b_rdat, b_rdata, b_rdatb;
  logic        b_busy;

  int checks;
  int errors;

  xrs_bypass #(.XLEN(64), .NREGS(32)) u_dut_a (
    .clk_i   (clk),
    .reset_i (a_reset),
    .we_i    (a_we),
    .rd_i    (a_rd),
    .wsz_i   (a_wsz),
    .wsx_i   (a_wsx),
    .rdat_i  (a_rdat),
    .ra_i    (a_ra),
    .rb_i    (a_rb),
    .rdata_o (a_rdata),
    .rdatb_o (a_rdatb),
    .busy_o  (a_busy)
  );

  xrs_bypass #(.XLEN(32), .NREGS(8)) u_dut_b (
    .clk_i   (clk),
    .reset_i (b_reset),
    .we_i    (b_we),
    .rd_i    (b_rd),
    .wsz_i   (b_wsz),
    .wsx_i   (b_wsx),
    .rdat_i  (b_rdat),
    .ra_i    (b_ra),
    .rb_i    (b_rb),
    .rdata_o (b_rdata),
    .rdatb_o (b_rdatb),
    .busy_o  (b_busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_write(input logic [4:0] rd, input logic [1:0] sz, input logic sx,
                         input logic [63:0] d);
    a_we = 1'b1; a_rd = rd; a_wsz = sz; a_wsx = sx; a_rdat = d;
    step();
    a_we = 1'b0;
  endtask

  task automatic a_read(input logic [4:0] ra, input logic [4:0] rb);
    a_ra = ra; a_rb = rb;
    step();
  endtask

  task automatic b_write(input logic [2:0] rd, input logic [1:0] sz, input logic sx,
                         input logic [31:0] d);
    b_we = 1'b1; b_rd = rd; b_wsz = sz; b_wsx = sx; b_rdat = d;
    step();
    b_we = 1'b0;
  endtask

  task automatic b_read(input logic [2:0] ra, input logic [2:0] rb);
    b_ra = ra; b_rb = rb;
    step();
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    a_reset = 1'b1; a_we = 1'b0; a_rd = '0; a_wsz = '0; a_wsx = 1'b0;
    a_rdat = '0; a_ra = '0; a_rb = '0;
    b_reset = 1'b1; b_we = 1'b0; b_rd = '0; b_wsz = '0; b_wsx = 1'b0;
    b_rdat = '0; b_ra = '0; b_rb = '0;

    // 1: reset, scrub length, everything reads zero
    step();
    step();
    chk("a_rst_busy", {63'd0, a_busy}, 64'd1);
    chk("a_rst_rdata", a_rdata, 64'd0);
    chk("a_rst_rdatb", a_rdatb, 64'd0);
    a_reset = 1'b0;
    n = 0;
    while (a_busy && n < 200) begin
      step();
      n++;
    end
    chk("a_scrub_len", 64'(n), 64'd31);
    for (int i = 0; i < 32; i++) begin
      a_read(5'(i), 5'(31 - i));
      chk("a_scrub_rda", a_rdata, 64'd0);
      chk("a_scrub_rdb", a_rdatb, 64'd0);
    end

    // 2: sign extension of each size
    a_write(5'd5, 2'd0, 1'b1, 64'h8766554483228180);
    a_write(5'd6, 2'd1, 1'b1, 64'h8766554483228180);
    a_write(5'd7, 2'd2, 1'b1, 64'h8766554483228180);
    a_write(5'd8, 2'd3, 1'b1, 64'h8766554483228180);
    a_read(5'd5, 5'd6);
    chk("a_sx_b", a_rdata, 64'hFFFFFFFFFFFFFF80);
    chk("a_sx_h", a_rdatb, 64'hFFFFFFFFFFFF8180);
    a_read(5'd7, 5'd8);
    chk("a_sx_w", a_rdata, 64'hFFFFFFFF83228180);
    chk("a_sx_x", a_rdatb, 64'h8766554483228180);

    // 3: zero extension
    a_write(5'd1, 2'd0, 1'b0, 64'hFFFFFFFFFFFFFFFF);
    a_write(5'd2, 2'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF);
    a_write(5'd3, 2'd2, 1'b0, 64'hFFFFFFFFFFFFFFFF);
    a_read(5'd1, 5'd2);
    chk("a_zx_b", a_rdata, 64'h00000000000000FF);
    chk("a_zx_h", a_rdatb, 64'h000000000000FFFF);
    a_read(5'd3, 5'd0);
    chk("a_zx_w", a_rdata, 64'h00000000FFFFFFFF);
    chk("a_x0_rdb", a_rdatb, 64'd0);

    // 4: bypass on both ports, x0 writes discarded
    a_ra = 5'd1; a_rb = 5'd1;
    a_write(5'd1, 2'd3, 1'b0, 64'h1122334455667788);
    chk("a_byp_a", a_rdata, 64'h1122334455667788);
    chk("a_byp_b", a_rdatb, 64'h1122334455667788);
    a_ra = 5'd0; a_rb = 5'd1;
    a_write(5'd0, 2'd3, 1'b0, 64'h000000000000DEAD);
    chk("a_x0_byp", a_rdata, 64'd0);
    chk("a_x1_keep", a_rdatb, 64'h1122334455667788);
    a_read(5'd0, 5'd2);
    chk("a_x0_read", a_rdata, 64'd0);
    chk("a_x2_keep", a_rdatb, 64'h000000000000FFFF);
    a_ra = 5'd9; a_rb = 5'd2;
    a_write(5'd9, 2'd0, 1'b1, 64'h0000000000000080);
    chk("a_byp_ext", a_rdata, 64'hFFFFFFFFFFFFFF80);
    chk("a_byp_other", a_rdatb, 64'h000000000000FFFF);

    // 5: writes during scrub are dropped
    a_write(5'd4, 2'd3, 1'b0, 64'h7766554433221100);
    a_read(5'd4, 5'd0);
    chk("a_x4_pre", a_rdata, 64'h7766554433221100);
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    chk("a_rst2_busy", {63'd0, a_busy}, 64'd1);
    chk("a_rst2_rdata", a_rdata, 64'd0);
    a_we = 1'b1; a_rd = 5'd4; a_wsz = 2'd3; a_wsx = 1'b0;
    a_rdat = 64'hAAAAAAAAAAAAAAAA; a_ra = 5'd4; a_rb = 5'd4;
    n = 0;
    while (a_busy && n < 200) begin
      step();
      n++;
      chk("a_busy_rda", a_rdata, 64'd0);
    end
    a_we = 1'b0;
    chk("a_scrub2_len", 64'(n), 64'd31);
    a_read(5'd4, 5'd1);
    chk("a_x4_drop", a_rdata, 64'd0);
    chk("a_x1_clr", a_rdatb, 64'd0);

    // 6: reset reasserted mid-scrub restarts the walk
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("a_mid_busy", {63'd0, a_busy}, 64'd1);
    end
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    chk("a_rst3_busy", {63'd0, a_busy}, 64'd1);
    n = 0;
    while (a_busy && n < 200) begin
      step();
      n++;
    end
    chk("a_scrub3_len", 64'(n), 64'd31);
    a_ra = 5'd31; a_rb = 5'd30;
    a_write(5'd31, 2'd1, 1'b1, 64'h0000000000007FFF);
    chk("a_post_byp", a_rdata, 64'h0000000000007FFF);
    chk("a_post_rdb", a_rdatb, 64'd0);

    // Narrow instance: XLEN=32, NREGS=8
    step();
    b_reset = 1'b0;
    chk("b_rst_busy", {63'd0, b_busy}, 64'd1);
    n = 0;
    while (b_busy && n < 50) begin
      step();
      n++;
    end
    chk("b_scrub_len", 64'(n), 64'd7);
    for (int i = 0; i < 8; i++) begin
      b_read(3'(i), 3'(7 - i));
      chk("b_scrub_rda", {32'd0, b_rdata}, 64'd0);
      chk("b_scrub_rdb", {32'd0, b_rdatb}, 64'd0);
    end
    b_write(3'd5, 2'd0, 1'b1, 32'h83228180);
    b_write(3'd6, 2'd1, 1'b1, 32'h83228180);
    b_write(3'd7, 2'd2, 1'b1, 32'h83228180);
    b_write(3'd1, 2'd3, 1'b1, 32'h83228180);
    b_read(3'd5, 3'd6);
    chk("b_sx_b", {32'd0, b_rdata}, 64'h00000000FFFFFF80);
    chk("b_sx_h", {32'd0, b_rdatb}, 64'h00000000FFFF8180);
    b_read(3'd7, 3'd1);
    chk("b_sx_w", {32'd0, b_rdata}, 64'h0000000083228180);
    chk("b_sx_x", {32'd0, b_rdatb}, 64'h0000000083228180);
    b_ra = 3'd0; b_rb = 3'd2;
    b_write(3'd2, 2'd0, 1'b0, 32'hFFFFFFFF);
    chk("b_x0", {32'd0, b_rdata}, 64'd0);
    chk("b_byp_zx", {32'd0, b_rdatb}, 64'h00000000000000FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
